// File: rtl/div_seq_if.sv
// Request/result bundle between the E stage and the iterative divider.
interface div_seq_if;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, signed_div, annul, a, b,
                    input  stall, ready, hi, lo);
    modport slave  (input  start, signed_div, annul, a, b,
                    output stall, ready, hi, lo);
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; LO = quotient, HI = remainder.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module div_seq (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [32:0] bmag;
    logic        neg_q, neg_r, bzero;
    logic [31:0] hi, lo;
    logic        stall, ready;

    logic        accept;
    logic        sa, sb, b_is_zero;
    logic [31:0] amag_in;
    logic [32:0] bmag_in;
    logic [32:0] sh;
    logic [33:0] diff;
    logic        ge;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_fix, r_fix;

    assign sa        = bus.signed_div & bus.a[31];
    assign sb        = bus.signed_div & bus.b[31];
    assign b_is_zero = (bus.b == 32'd0);
    // |0x80000000| is 0x80000000, which is exact as an unsigned 32-bit value
    assign amag_in   = sa ? (32'd0 - bus.a) : bus.a;
    assign bmag_in   = sb ? (33'd0 - {bus.b[31], bus.b}) : {1'b0, bus.b};
    assign accept    = bus.start & ~bus.annul;

    // One restoring step: shift {rem, quo}, trial-subtract, keep on non-negative
    assign sh        = {rem[31:0], quo[31]};
    assign diff      = {1'b0, sh} - {1'b0, bmag};
    assign ge        = ~diff[33];
    assign rem_step  = ge ? diff[32:0] : sh;
    assign quo_step  = {quo[30:0], ge};
    assign q_fix     = neg_q ? (32'd0 - quo_step) : quo_step;
    // With b == 0 every trial succeeds, so rem ends at |a| and the fix-up restores a
    assign r_fix     = neg_r ? (32'd0 - rem_step[31:0]) : rem_step[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = b_is_zero ? DONE : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                stall = ~bus.annul;
                if (bus.annul)        state_nxt = IDLE;
                else if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 5'd0;
            rem   <= 33'd0;
            quo   <= 32'd0;
            bmag  <= 33'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            bzero <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt   <= 5'd0;
                    rem   <= 33'd0;
                    quo   <= amag_in;
                    bmag  <= bmag_in;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    bzero <= b_is_zero;
`ifdef DIV_ZERO_FAST_EN
                    if (b_is_zero) begin
                        hi <= bus.a;
                        lo <= 32'hFFFF_FFFF;
                    end
`endif
                end
                BUSY: if (!bus.annul) begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        hi <= r_fix;
                        lo <= bzero ? 32'hFFFF_FFFF : q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall = stall;
    assign bus.ready = ready;
    assign bus.hi    = hi;
    assign bus.lo    = lo;
endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results, div-by-zero, annul, reset.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_seq_if bus ();

    div_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds start from cycle 0 until the ready pulse, then drops it in the IDLE cycle after
    task automatic run_div(input string tag, input logic sd, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] elo, input logic [31:0] ehi, input int lat);
        int stall_n;
        int rdy_at;
        stall_n = 0;
        rdy_at  = -1;
        bus.signed_div = sd;
        bus.a          = va;
        bus.b          = vb;
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        for (int c = 0; c < 40 && rdy_at < 0; c++) begin
            #1;
            if (bus.stall) stall_n++;
            if (bus.ready) rdy_at = c;
            tick();
        end
        bus.start = 1'b0;
        chk({tag, ".stall_cycles"}, 32'(stall_n), 32'(lat));
        chk({tag, ".ready_cycle"}, 32'(rdy_at), 32'(lat));
        chk({tag, ".lo"}, bus.lo, elo);
        chk({tag, ".hi"}, bus.hi, ehi);
        #1;
        chk({tag, ".ready_drop"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        int rdy_n;
        int r1;
        int r2;
        bus.start = 0; bus.signed_div = 0; bus.annul = 0; bus.a = 0; bus.b = 0;
        #3;
        chk("reset.hi", bus.hi, 32'd0);
        chk("reset.lo", bus.lo, 32'd0);
        chk("reset.ready", 32'(bus.ready), 32'd0);
        chk("reset.stall", 32'(bus.stall), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div_wrap", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("div_by_zero", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, DZ_LAT);
        run_div("div_neg_by_zero", 1'b1, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 32'h8000_0001, DZ_LAT);

        // Annul in cycle 10: stall drops immediately, no result, old hi/lo survive
        rdy_n = 0;
        bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.ready) rdy_n++;
            tick();
        end
        bus.annul = 1'b1;
        #1;
        chk("annul.stall", 32'(bus.stall), 32'd0);
        chk("annul.ready", 32'(bus.ready | (rdy_n != 0)), 32'd0);
        tick();
        bus.annul = 1'b0;
        chk("annul.hi_kept", bus.hi, 32'h8000_0001);
        chk("annul.lo_kept", bus.lo, 32'hFFFF_FFFF);
        run_div("after_annul", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);

        // Reset in cycle 5 of a divide
        bus.signed_div = 1'b1; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; bus.start = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("midrst.hi", bus.hi, 32'd0);
        chk("midrst.lo", bus.lo, 32'd0);
        chk("midrst.ready", 32'(bus.ready), 32'd0);
        chk("midrst.stall", 32'(bus.stall), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("postrst.idle_stall", 32'(bus.stall), 32'd0);

        // Back-to-back with start held continuously
        rdy_n = 0; r1 = -1; r2 = -1;
        bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        for (int c = 0; c < 80 && rdy_n < 2; c++) begin
            #1;
            if (bus.ready) begin
                if (rdy_n == 0) r1 = c; else r2 = c;
                rdy_n++;
            end
            tick();
        end
        bus.start = 1'b0;
        chk("b2b.pulses", 32'(rdy_n), 32'd2);
        chk("b2b.first", 32'(r1), 32'd33);
        chk("b2b.gap", 32'(r2 - r1), 32'd34);
        chk("b2b.lo", bus.lo, 32'd14);
        chk("b2b.hi", bus.hi, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider sequencer for the MIPS pipeline's DIV/DIVU instructions. It sits beside the execute-stage ALU and accepts a division request from the E stage. It holds the pipeline stalled while it runs a radix-2 restoring division, then presents the quotient and remainder for the HI/LO write path (LO = quotient, HI = remainder). A flush or exception in E cancels the operation.

## Interface
Parameters:
- none. The width is fixed at 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous reset, active-low
- start  input  1  a DIV/DIVU instruction is in E; held high for as long as that instruction stays in E
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
- a  input  32  dividend (rs value in E); sampled on accept
- b  input  32  divisor (rt value in E); sampled on accept
- annul  input  1  E-stage flush/exception; cancels any pending or running divide
- stall  output  1  freeze F/D/E stages; combinational
- ready  output  1  one-cycle pulse; hi/lo are valid and the instruction may leave E
- hi  output  32  remainder
- lo  output  32  quotient

## Operation
- States:
  - IDLE: no divide in progress.
  - BUSY: iterating; a 5-bit counter cnt runs 0..31.
  - DONE: result presented for one cycle.
- IDLE:
  - stall = start & ~annul.
  - If start & ~annul, latch |a|, |b|, the sign flags and signed_div, clear the partial remainder, set cnt = 0, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall = ~annul.
  - Each cycle performs one restoring step: shift {rem, quo} left by 1, trial-subtract |b| from rem, and set the quotient bit if the result is non-negative.
  - cnt increments each cycle; at cnt == 31 go to DONE.
  - If annul is high, go to IDLE with no result update and no ready pulse.
- DONE:
  - stall = 0 and ready = 1.
  - hi/lo are loaded at the edge entering DONE. They hold until the next accepted divide's DONE, or until reset.
  - Next state is always IDLE.
  - start is ignored in DONE, because it is still the same instruction.
- Sign fix-up, applied when loading hi/lo:
  - Only when signed_div is set.
  - The quotient is negated if sign(a) != sign(b).
  - The remainder takes the sign of a.
  - DIVU treats both operands as unsigned.
- Magnitudes use 33-bit arithmetic internally, so |0x80000000| is exact.
- Signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This is the wrap result, and no overflow is flagged.
- Divide by zero (b == 0) forces lo = 0xFFFFFFFF and hi = a, for both signed and unsigned. The timing depends on the Configuration section.
- annul in IDLE: the request is not accepted and stall stays 0.

## Timing
- Reset (rst low, asynchronous) forces:
  - state = IDLE, cnt = 0
  - hi = 0, lo = 0, ready = 0
  - stall = 0, or follows start & ~annul combinationally once in IDLE
- Reset mid-BUSY aborts immediately. No ready pulse is produced.
- Normal latency:
  - Cycle 0: accept in IDLE.
  - Cycles 1..32: BUSY.
  - Cycle 33: DONE.
  - stall is high for exactly 33 cycles (0..32). ready is high in cycle 33 only.
- Back-to-back divides: the instruction following in E can be accepted in the cycle after DONE, so there is no lost cycle beyond IDLE re-entry.
- stall responds to annul in the same cycle, so the flushed pipeline is never frozen by a cancelled divide.

## Configuration
- DIV_ZERO_FAST_EN
  - Defined: b == 0 at accept skips BUSY (IDLE → DONE). stall is high for 1 cycle and ready arrives in cycle 1.
  - Undefined: a divide by zero runs the full 32 iterations with the normal 33-cycle stall. The result is forced to lo = 0xFFFFFFFF, hi = a in both builds.

## Test plan
- Unsigned: DIVU a = 100, b = 7 → stall high for cycles 0–32, ready in cycle 33, lo = 14, hi = 2.
- Signed: DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Divide by zero: a = 0x12345678, b = 0 → lo = 0xFFFFFFFF, hi = 0x12345678. ready in cycle 1 with DIV_ZERO_FAST_EN defined, cycle 33 without.
- Annul: assert annul in cycle 10 of a divide → stall = 0 in that cycle, no ready pulse, hi/lo keep their prior values. A new start in the next cycle completes normally.
- Reset and back-to-back: drive rst low in cycle 5 → state IDLE, hi = lo = ready = 0. After release, run two consecutive divides with start held continuously → two ready pulses, 34 cycles apart.
